// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-decade BCD up/down counter with parallel load, a combinational
// terminal-count flag, a registered rollover pulse and a registered pulse that
// flags an invalid load digit.
//
// Configuration macro:
//   BCD_COUNTER_SAT_EN  - when defined, the counter saturates at all-9s
//                         (counting up) and at all-0s (counting down) and
//                         never raises wrap. When undefined, it rolls over.
//
// Parameters:
//   DIGITS     - number of BCD decades (1..8)
//   RESET_VAL  - packed BCD value loaded on reset (every nibble <= 9)
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   en        in   count enable
//   up_down   in   1 = count up, 0 = count down
//   load      in   synchronous parallel load strobe (overrides en)
//   load_val  in   packed BCD load value, nibble 0 = least-significant decade
//   count     out  registered packed BCD count
//   tc        out  combinational terminal count (en and count at boundary)
//   wrap      out  registered one-cycle pulse after a rollover edge
//   load_err  out  registered one-cycle pulse after a load with a nibble > 9
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int                    DIGITS    = 4,
  parameter logic [4*DIGITS-1:0]   RESET_VAL = {(4*DIGITS){1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int                  W         = 4 * DIGITS;
  localparam logic [W-1:0]        ALL_NINES = {DIGITS{4'h9}};
  localparam logic [W-1:0]        ALL_ZEROS = {W{1'b0}};

  // Ripple increment: a decade at 9 (or anything out of range) receiving a
  // carry becomes 0 and passes the carry upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         carry;
    logic [3:0]   d;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d >= 4'd9) begin
          res[4*i +: 4] = 4'd0;
          carry         = 1'b1;
        end else begin
          res[4*i +: 4] = d + 4'd1;
          carry         = 1'b0;
        end
      end else begin
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction

  // Ripple decrement: a decade at 0 receiving a borrow becomes 9 and borrows
  // from the next decade up.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    logic [3:0]   d;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          res[4*i +: 4] = 4'd9;
          borrow        = 1'b1;
        end else if (d > 4'd9) begin
          res[4*i +: 4] = 4'd9;
          borrow        = 1'b0;
        end else begin
          res[4*i +: 4] = d - 4'd1;
          borrow        = 1'b0;
        end
      end else begin
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction

  // Replace every nibble above 9 with 0 so count never holds a non-BCD digit.
  function automatic logic [W-1:0] sanitize_bcd(input logic [W-1:0] v);
    logic [W-1:0] res;
    res = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        res[4*i +: 4] = 4'd0;
      end else begin
        res[4*i +: 4] = v[4*i +: 4];
      end
    end
    return res;
  endfunction

  // True when any nibble of the value is not a legal BCD digit.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  logic [W-1:0] count_r;
  logic         wrap_r;
  logic         load_err_r;

  logic [W-1:0] inc_s;
  logic [W-1:0] dec_s;
  logic         at_limit_s;
  logic [W-1:0] next_count_s;
  logic         next_wrap_s;
  logic         next_err_s;

  // Next-state selection: load beats en; hold when neither is active.
  always_comb begin
    inc_s        = bcd_inc(count_r);
    dec_s        = bcd_dec(count_r);
    at_limit_s   = up_down ? (count_r == ALL_NINES) : (count_r == ALL_ZEROS);
    next_count_s = count_r;
    next_wrap_s  = 1'b0;
    next_err_s   = 1'b0;
    if (load) begin
      next_count_s = sanitize_bcd(load_val);
      next_err_s   = has_bad_digit(load_val);
    end else if (en) begin
`ifdef BCD_COUNTER_SAT_EN
      if (at_limit_s) begin
        next_count_s = count_r;
      end else begin
        next_count_s = up_down ? inc_s : dec_s;
      end
`else
      next_count_s = up_down ? inc_s : dec_s;
      next_wrap_s  = at_limit_s;
`endif
    end else begin
      next_count_s = count_r;
    end
  end

  // State register with synchronous reset; reset also cancels pending pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= RESET_VAL;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= next_count_s;
      wrap_r     <= next_wrap_s;
      load_err_r <= next_err_s;
    end
  end

  assign count    = count_r;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;
  assign tc       = en & at_limit_s;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// Testbench for bcd_updown_counter (DIGITS=2). A decimal reference model
// predicts each edge; predictions are queued when stimulus is driven and
// popped for comparison one cycle later. A second instance with RESET_VAL=25
// covers the reset-value parameter.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_down;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;
  logic       wrap;
  logic       load_err;
  logic [7:0] count2;
  logic       tc2;
  logic       wrap2;
  logic       load_err2;

  typedef struct {
    logic [7:0] count;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run;
  int         tests_failed;
  logic [7:0] m_count;
  bit         m_valid;
  int         wrap_seen;

  bcd_updown_counter #(.DIGITS(2), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  bcd_updown_counter #(.DIGITS(2), .RESET_VAL(8'h25)) dut25 (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count(count2), .tc(tc2), .wrap(wrap2), .load_err(load_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'((n / 10) % 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Drive one edge worth of stimulus, predict, then compare after the edge.
  task automatic cycle(input bit r, input bit l, input bit e, input bit ud,
                       input logic [7:0] lv, input string tag);
    exp_t x;
    int   val;
    logic exp_tc;
    rst = r; load = l; en = e; up_down = ud; load_val = lv;
    #1;
    if (m_valid) begin
      exp_tc = e && (ud ? (m_count == 8'h99) : (m_count == 8'h00));
      check_value({tag, ".tc"}, {31'd0, tc}, {31'd0, exp_tc});
    end
    x.wrap = 1'b0;
    x.err  = 1'b0;
    if (r) begin
      m_count = 8'h00;
      m_valid = 1'b1;
    end else if (l) begin
      x.err   = (lv[7:4] > 4'd9) || (lv[3:0] > 4'd9);
      m_count[7:4] = (lv[7:4] > 4'd9) ? 4'd0 : lv[7:4];
      m_count[3:0] = (lv[3:0] > 4'd9) ? 4'd0 : lv[3:0];
    end else if (e) begin
      val = bcd2int(m_count);
`ifdef BCD_COUNTER_SAT_EN
      if (ud && val < 99) val = val + 1;
      else if (!ud && val > 0) val = val - 1;
`else
      if (ud) begin
        if (val == 99) begin val = 0; x.wrap = 1'b1; end
        else val = val + 1;
      end else begin
        if (val == 0) begin val = 99; x.wrap = 1'b1; end
        else val = val - 1;
      end
`endif
      m_count = int2bcd(val);
    end
    x.count = m_count;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_value({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      if (m_valid) check_value({tag, ".count"}, {24'd0, count}, {24'd0, x.count});
      check_value({tag, ".wrap"}, {31'd0, wrap}, {31'd0, x.wrap});
      check_value({tag, ".load_err"}, {31'd0, load_err}, {31'd0, x.err});
      if (wrap === 1'b1) wrap_seen++;
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; m_valid = 1'b0; m_count = 8'h00; wrap_seen = 0;
    rst = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0; load_val = 8'h00;

    // Reset with load and en also asserted: reset wins.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h42, "reset");
    check_value("reset25.count", {24'd0, count2}, 32'h25);
    check_value("reset25.wrap", {31'd0, wrap2}, 32'd0);
    check_value("reset25.err", {31'd0, load_err2}, 32'd0);

    // 100 up edges: full cycle 00..99 -> 00.
    wrap_seen = 0;
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "up100");
    check_value("up100.final", {24'd0, count}, 32'h00);
`ifndef BCD_COUNTER_SAT_EN
    check_value("up100.wraps", wrap_seen, 32'd1);
`endif

    // Borrow across a decade.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, "ld10");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dn09");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dn08");
    check_value("dn08.value", {24'd0, count}, 32'h08);

    // Invalid digit on load: sanitised, one-cycle error pulse.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, "ld3c");
    check_value("ld3c.value", {24'd0, count}, 32'h30);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "ld3c_hold");

    // Load overrides a rollover-pending count step.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, "ld99");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h42, "ld42_over");
    check_value("ld42.value", {24'd0, count}, 32'h42);

    // Reset and load together from 57; RESET_VAL instance returns to 25.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h57, "ld57");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, "rst_ld");
    check_value("rst_ld25.count", {24'd0, count2}, 32'h25);
    check_value("rst_ld25.err", {31'd0, load_err2}, 32'd0);
    check_value("rst_ld25.tc", {31'd0, tc2}, 32'd0);

    // Down from 00 (wrap to 99, or saturate), then immediate direction change.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dn_from0");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "dir_up");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dir_dn");
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "hold");

    // Reset at 99 while counting up aborts the wrap pulse.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, "ld99b");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "rst_abort");

`ifdef BCD_COUNTER_SAT_EN
    // Saturation at zero: three down edges hold 00 with tc high.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "sat0");
      check_value("sat0.value", {24'd0, count}, 32'h00);
    end
`endif

    // Random traffic including invalid load digits and occasional reset.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
